// File: rtl/local_mean_3x3_pkg.sv
// Shared types and constants for the 3x3 local-mean stage and later window stages.
package local_mean_3x3_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StRead,
        StWrite,
        StDone
    } state_e;

    localparam int unsigned TAPS        = 9;
    localparam int unsigned RECIP9      = 7282;
    localparam int unsigned RECIP_SHIFT = 16;
    localparam int unsigned ACC_W       = 12;
    localparam int unsigned TAP_W       = 4;

    // Offset codes: 0 -> -1, 1 -> 0, 2 -> +1. Row is the outer loop of the tap order.
    function automatic logic [1:0] tap_dy(input logic [TAP_W-1:0] tap);
        case (tap)
            4'd0, 4'd1, 4'd2: return 2'd0;
            4'd3, 4'd4, 4'd5: return 2'd1;
            default:          return 2'd2;
        endcase
    endfunction

    function automatic logic [1:0] tap_dx(input logic [TAP_W-1:0] tap);
        case (tap)
            4'd0, 4'd3, 4'd6: return 2'd0;
            4'd1, 4'd4, 4'd7: return 2'd1;
            default:          return 2'd2;
        endcase
    endfunction

endpackage

// File: rtl/div_by_9.sv
// Combinational floor(S/9) for S in 0..2295 using a reciprocal multiply.
module div_by_9
    import local_mean_3x3_pkg::*;
(
    input  logic [ACC_W-1:0] sum_i,
    output logic [7:0]       mean_o
);

    localparam int unsigned PROD_W = RECIP_SHIFT + 8;

    logic [PROD_W-1:0] prod;

    // 2295 * 7282 still fits below 2**24, so the product cannot overflow.
    assign prod   = PROD_W'(sum_i) * PROD_W'(RECIP9);
    assign mean_o = 8'(prod >> RECIP_SHIFT);

endmodule

// File: rtl/local_mean_3x3.sv
// Full-frame 3x3 box mean with border replication: reads the image memory tap by tap
// and writes floor(sum/9) per pixel into the threshold memory.
module local_mean_3x3
    import local_mean_3x3_pkg::*;
#(
    parameter int unsigned WIDTH_BITS  = 8,
    parameter int unsigned HEIGHT_BITS = 8
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   start,
    output logic [WIDTH_BITS-1:0]  oImageCol,
    output logic [HEIGHT_BITS-1:0] oImageRow,
    input  logic [7:0]             iImageData,
    output logic [WIDTH_BITS-1:0]  oThresholdCol,
    output logic [HEIGHT_BITS-1:0] oThresholdRow,
    output logic [7:0]             oThresholdData,
    output logic                   oThresholdWren,
    output logic                   busy,
    output logic                   finished
);

    localparam int unsigned WIDTH  = 2 ** WIDTH_BITS;
    localparam int unsigned HEIGHT = 2 ** HEIGHT_BITS;
    localparam int unsigned PIX_W  = WIDTH_BITS + HEIGHT_BITS;

    localparam logic [WIDTH_BITS-1:0]  COL_MAX = WIDTH_BITS'(WIDTH - 1);
    localparam logic [HEIGHT_BITS-1:0] ROW_MAX = HEIGHT_BITS'(HEIGHT - 1);

    state_e                 state_q, state_d;
    logic [PIX_W-1:0]       pix_q, pix_d;
    logic [TAP_W-1:0]       tap_q, tap_d;
    logic [ACC_W-1:0]       acc_q, acc_d;
    logic [WIDTH_BITS-1:0]  img_col_q, img_col_d;
    logic [HEIGHT_BITS-1:0] img_row_q, img_row_d;
    logic [WIDTH_BITS-1:0]  thr_col_q, thr_col_d;
    logic [HEIGHT_BITS-1:0] thr_row_q, thr_row_d;
    logic [7:0]             thr_data_q, thr_data_d;
    logic                   thr_wren_q, thr_wren_d;

    logic                   issue;
    logic [PIX_W-1:0]       addr_pix;
    logic [TAP_W-1:0]       addr_tap;
    logic [WIDTH_BITS-1:0]  cur_col, tap_col;
    logic [HEIGHT_BITS-1:0] cur_row, tap_row;
    logic [ACC_W-1:0]       sum;
    logic [7:0]             mean;

    assign sum = acc_q + ACC_W'(iImageData);

    div_by_9 u_div (
        .sum_i  (sum),
        .mean_o (mean)
    );

    // Which pixel/tap address is presented to the image memory in the next cycle.
    always_comb begin
        issue    = 1'b0;
        addr_pix = pix_q;
        addr_tap = tap_q + TAP_W'(1);
        case (state_q)
            StRead: begin
                issue = (tap_q < TAP_W'(TAPS - 1));
            end
            StWrite: begin
                issue    = (pix_q != '1);
                addr_pix = pix_q + PIX_W'(1);
                addr_tap = '0;
            end
            StIdle, StDone: begin
                issue    = start;
                addr_pix = '0;
                addr_tap = '0;
            end
            default: ;
        endcase
    end

    // Clamp neighbour coordinates to the frame (border replication).
    always_comb begin
        cur_col = addr_pix[WIDTH_BITS-1:0];
        cur_row = addr_pix[PIX_W-1:WIDTH_BITS];
        case (tap_dx(addr_tap))
            2'd0:    tap_col = (cur_col == '0) ? cur_col : cur_col - WIDTH_BITS'(1);
            2'd2:    tap_col = (cur_col == COL_MAX) ? cur_col : cur_col + WIDTH_BITS'(1);
            default: tap_col = cur_col;
        endcase
        case (tap_dy(addr_tap))
            2'd0:    tap_row = (cur_row == '0) ? cur_row : cur_row - HEIGHT_BITS'(1);
            2'd2:    tap_row = (cur_row == ROW_MAX) ? cur_row : cur_row + HEIGHT_BITS'(1);
            default: tap_row = cur_row;
        endcase
    end

    always_comb begin
        state_d    = state_q;
        pix_d      = pix_q;
        tap_d      = tap_q;
        acc_d      = acc_q;
        img_col_d  = issue ? tap_col : img_col_q;
        img_row_d  = issue ? tap_row : img_row_q;
        thr_col_d  = thr_col_q;
        thr_row_d  = thr_row_q;
        thr_data_d = thr_data_q;
        thr_wren_d = 1'b0;
        case (state_q)
            StIdle, StDone: begin
                if (start) begin
                    state_d = StRead;
                    pix_d   = '0;
                    tap_d   = '0;
                    acc_d   = '0;
                end
            end
            StRead: begin
                // Data of tap k arrives while tap k+1 is addressed.
                if (tap_q != '0) begin
                    acc_d = sum;
                end
                if (tap_q == TAP_W'(TAPS)) begin
                    state_d    = StWrite;
                    thr_wren_d = 1'b1;
                    thr_col_d  = pix_q[WIDTH_BITS-1:0];
                    thr_row_d  = pix_q[PIX_W-1:WIDTH_BITS];
                    thr_data_d = mean;
                end else begin
                    tap_d = tap_q + TAP_W'(1);
                end
            end
            StWrite: begin
                if (pix_q == '1) begin
                    state_d = StDone;
                end else begin
                    state_d = StRead;
                    pix_d   = pix_q + PIX_W'(1);
                    tap_d   = '0;
                    acc_d   = '0;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q    <= StIdle;
            pix_q      <= '0;
            tap_q      <= '0;
            acc_q      <= '0;
            img_col_q  <= '0;
            img_row_q  <= '0;
            thr_col_q  <= '0;
            thr_row_q  <= '0;
            thr_data_q <= '0;
            thr_wren_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            pix_q      <= pix_d;
            tap_q      <= tap_d;
            acc_q      <= acc_d;
            img_col_q  <= img_col_d;
            img_row_q  <= img_row_d;
            thr_col_q  <= thr_col_d;
            thr_row_q  <= thr_row_d;
            thr_data_q <= thr_data_d;
            thr_wren_q <= thr_wren_d;
        end
    end

    assign oImageCol      = img_col_q;
    assign oImageRow      = img_row_q;
    assign oThresholdCol  = thr_col_q;
    assign oThresholdRow  = thr_row_q;
    assign oThresholdData = thr_data_q;
    assign oThresholdWren = thr_wren_q;
    assign busy           = (state_q == StRead) || (state_q == StWrite);
    assign finished       = (state_q == StDone);

endmodule

// File: tb/tb_local_mean_3x3.sv
// Bench for local_mean_3x3 on a 4x4 frame with a 1-cycle-latency image memory model.
module tb_local_mean_3x3;

    typedef struct {
        int col;
        int row;
        int data;
    } wr_t;

    typedef struct {
        int pat;
        int col;
        int row;
        int exp;
    } vec_t;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic       start = 1'b0;
    logic [1:0] img_col, img_row, thr_col, thr_row;
    logic [7:0] img_data = 8'd0;
    logic [7:0] thr_data;
    logic       thr_wren, busy, finished;

    logic [7:0] img [16];
    int         thr_mem [16];
    wr_t        exp_q [$];
    vec_t       vecs [$];
    int         tests = 0;
    int         fails = 0;
    int         wr_count = 0;

    local_mean_3x3 #(
        .WIDTH_BITS  (2),
        .HEIGHT_BITS (2)
    ) dut (
        .clock          (clock),
        .reset          (reset),
        .start          (start),
        .oImageCol      (img_col),
        .oImageRow      (img_row),
        .iImageData     (img_data),
        .oThresholdCol  (thr_col),
        .oThresholdRow  (thr_row),
        .oThresholdData (thr_data),
        .oThresholdWren (thr_wren),
        .busy           (busy),
        .finished       (finished)
    );

    always #5 clock = ~clock;

    always @(posedge clock) img_data <= img[{img_row, img_col}];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Scoreboard: every write must match the next expected pixel in raster order.
    always @(posedge clock) begin
        #1;
        if (thr_wren === 1'b1) begin
            if (exp_q.size() == 0) begin
                check("unexpected_write", 1, 0);
            end else begin
                wr_t e;
                e = exp_q.pop_front();
                check("write_col", thr_col, e.col);
                check("write_row", thr_row, e.row);
                check("write_data", thr_data, e.data);
                thr_mem[thr_row * 4 + thr_col] = thr_data;
                wr_count++;
            end
        end
    end

    function automatic int ref_mean(input int c, input int r);
        int s, cc, rr;
        s = 0;
        for (int dr = -1; dr <= 1; dr++) begin
            for (int dc = -1; dc <= 1; dc++) begin
                cc = c + dc;
                rr = r + dr;
                if (cc < 0) cc = 0;
                if (cc > 3) cc = 3;
                if (rr < 0) rr = 0;
                if (rr > 3) rr = 3;
                s += int'(img[rr * 4 + cc]);
            end
        end
        return s / 9;
    endfunction

    task automatic load_pattern(input int p);
        for (int i = 0; i < 16; i++) begin
            case (p)
                0:       img[i] = 8'd100;
                1:       img[i] = (i == 5) ? 8'd255 : 8'd0;
                2:       img[i] = (i == 0) ? 8'd255 : 8'd0;
                3:       img[i] = 8'd255;
                4:       img[i] = 8'((i / 4) * 8 + (i % 4));
                default: img[i] = 8'($urandom_range(0, 255));
            endcase
        end
    endtask

    task automatic push_expected();
        for (int r = 0; r < 4; r++) begin
            for (int c = 0; c < 4; c++) begin
                exp_q.push_back('{col: c, row: r, data: ref_mean(c, r)});
            end
        end
    endtask

    task automatic pulse_start();
        @(negedge clock);
        start = 1'b1;
        @(posedge clock);
        #1;
        start = 1'b0;
    endtask

    // Runs one frame; extra start pulses land in the cycles numbered e1/e2 after the start edge.
    task automatic run_frame(input int e1, input int e2);
        int edges;
        push_expected();
        wr_count = 0;
        pulse_start();
        check("busy_after_start", busy, 1);
        check("finished_after_start", finished, 0);
        edges = 0;
        while (finished !== 1'b1 && edges < 400) begin
            @(posedge clock);
            #1;
            edges++;
            start = (edges == e1 || edges == e2);
        end
        start = 1'b0;
        check("frame_len", edges, 176);
        check("write_count", wr_count, 16);
        check("busy_done", busy, 0);
        check("pending_writes", exp_q.size(), 0);
        exp_q.delete();
    endtask

    task automatic check_table(input int p);
        foreach (vecs[i]) begin
            if (vecs[i].pat == p) begin
                check($sformatf("pat%0d_px%0d_%0d", p, vecs[i].col, vecs[i].row),
                      thr_mem[vecs[i].row * 4 + vecs[i].col], vecs[i].exp);
            end
        end
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        vecs = '{
            '{0, 0, 0, 100}, '{0, 3, 3, 100}, '{0, 2, 1, 100},
            '{1, 0, 0, 28},  '{1, 1, 1, 28},  '{1, 2, 2, 28},
            '{1, 3, 1, 0},   '{1, 1, 3, 0},   '{1, 3, 3, 0},
            '{2, 0, 0, 113}, '{2, 1, 0, 56},  '{2, 0, 1, 56},
            '{2, 1, 1, 28},  '{2, 2, 0, 0},
            '{3, 0, 0, 255}, '{3, 3, 3, 255}, '{3, 1, 2, 255},
            '{4, 0, 0, 3},   '{4, 1, 1, 9},   '{4, 3, 3, 24}
        };
        load_pattern(0);
        repeat (3) @(posedge clock);
        @(negedge clock);
        reset = 1'b0;
        check("rst_img_col", img_col, 0);
        check("rst_img_row", img_row, 0);
        check("rst_thr_col", thr_col, 0);
        check("rst_thr_row", thr_row, 0);
        check("rst_thr_data", thr_data, 0);
        check("rst_wren", thr_wren, 0);
        check("rst_busy", busy, 0);
        check("rst_finished", finished, 0);

        for (int p = 0; p < 5; p++) begin
            load_pattern(p);
            run_frame(0, 0);
            check_table(p);
        end

        // Start while busy is ignored; start in DONE repeats the identical frame.
        load_pattern(5);
        run_frame(10, 100);
        run_frame(0, 0);

        // Abort mid-pass, then a clean restart.
        load_pattern(4);
        push_expected();
        pulse_start();
        repeat (49) begin
            @(posedge clock);
            #1;
        end
        reset = 1'b1;
        exp_q.delete();
        @(posedge clock);
        #1;
        reset = 1'b0;
        check("abort_wren", thr_wren, 0);
        check("abort_busy", busy, 0);
        check("abort_finished", finished, 0);
        check("abort_img_col", img_col, 0);
        check("abort_thr_data", thr_data, 0);
        repeat (30) @(posedge clock);
        #1;
        check("abort_idle", busy, 0);
        run_frame(0, 0);
        check_table(4);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
